// File: rtl/noc_mesh_router.sv
// noc_mesh_router: 5-port (N,S,E,W,L) XY mesh router with input FIFOs, per-output round-robin
// arbitration and credit flow control. Define NOC_ROUTER_STATS_EN for per-output grant counters.
module noc_mesh_router #(
  parameter int unsigned XCOORD     = 0,
  parameter int unsigned YCOORD     = 0,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CREDITS    = 4,
  parameter logic [4:0]  PORT_MASK  = 5'h1F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5*DATA_W-1:0] data_i,
  input  logic [4:0]          valid_i,
  output logic [4:0]          credit_o,
  output logic [5*DATA_W-1:0] data_o,
  output logic [4:0]          valid_o,
  input  logic [4:0]          credit_i,
  output logic [4:0]          route_err_o,
  output logic [4:0]          ovf_o,
  output logic [5*16-1:0]     stats_o
);

  localparam int NP    = 5;
  localparam int PortN = 0;
  localparam int PortS = 1;
  localparam int PortE = 2;
  localparam int PortW = 3;
  localparam int PortL = 4;

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CrW  = $clog2(CREDITS + 1);

  localparam logic [3:0]      XC      = 4'(XCOORD);
  localparam logic [3:0]      YC      = 4'(YCOORD);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [CrW-1:0]  MaxCr   = CrW'(CREDITS);

  // Input FIFO state
  logic [DATA_W-1:0] mem_q    [NP][FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q [NP];
  logic [PtrW-1:0]   wr_ptr_q [NP];
  logic [CntW-1:0]   cnt_q    [NP];
  logic [CntW-1:0]   cnt_d    [NP];

  // Output side state
  logic [CrW-1:0]    cr_q     [NP];
  logic [CrW-1:0]    cr_d     [NP];
  logic [2:0]        ptr_q    [NP];
  logic [2:0]        ptr_d    [NP];
  logic [DATA_W-1:0] dout_q   [NP];
  logic [4:0]        valid_q;
  logic [4:0]        credit_q;
  logic [4:0]        rerr_q;
  logic [4:0]        ovf_q;

  logic [DATA_W-1:0] head     [NP];
  logic [4:0]        head_vld;
  logic [4:0]        route_oh [NP];
  logic [4:0]        route_bad;
  logic [4:0]        req      [NP];
  logic [4:0]        gnt_vld;
  logic [DATA_W-1:0] gnt_data [NP];
  logic [4:0]        pop;
  logic [4:0]        wr_en;
  logic [4:0]        accept;
  logic [4:0]        ovf_set;

  // Head flit and XY route per input
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      head[p]      = mem_q[p][rd_ptr_q[p]];
      head_vld[p]  = PORT_MASK[p] && (cnt_q[p] != '0);
      route_oh[p]  = '0;
      if (head[p][7:4] != XC) begin
        if (head[p][7:4] > XC) route_oh[p][PortE] = 1'b1;
        else                   route_oh[p][PortW] = 1'b1;
      end else if (head[p][3:0] != YC) begin
        if (head[p][3:0] > YC) route_oh[p][PortN] = 1'b1;
        else                   route_oh[p][PortS] = 1'b1;
      end else begin
        route_oh[p][PortL] = 1'b1;
      end
      route_bad[p] = head_vld[p] && ((route_oh[p] & PORT_MASK) == '0);
    end
  end

  // Mesh U-turns are never requested; local loopback (L to L) is a legal delivery.
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      req[o] = '0;
      for (int i = 0; i < NP; i++) begin
        req[o][i] = head_vld[i] && route_oh[i][o] && PORT_MASK[o] &&
                    ((i != o) || (o == PortL));
      end
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    pop = route_bad;
    for (int o = 0; o < NP; o++) begin
      gnt_vld[o]  = 1'b0;
      gnt_data[o] = '0;
      ptr_d[o]    = ptr_q[o];
      if (cr_q[o] != '0) begin
        for (int k = 1; k <= NP; k++) begin
          idx = (int'(ptr_q[o]) + k) % NP;
          if (!gnt_vld[o] && req[o][idx]) begin
            gnt_vld[o]  = 1'b1;
            gnt_data[o] = head[idx];
            ptr_d[o]    = 3'(idx);
            pop[idx]    = 1'b1;
          end
        end
      end
    end
  end

  // A pop in the same cycle frees the slot for a write to a full FIFO.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      wr_en[p]   = valid_i[p] && PORT_MASK[p];
      accept[p]  = wr_en[p] && ((cnt_q[p] != FullCnt) || pop[p]);
      ovf_set[p] = wr_en[p] && (cnt_q[p] == FullCnt) && !pop[p];
      cnt_d[p]   = cnt_q[p];
      if (accept[p] && !pop[p])      cnt_d[p] = cnt_q[p] + CntW'(1);
      else if (!accept[p] && pop[p]) cnt_d[p] = cnt_q[p] - CntW'(1);
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) begin
      cr_d[o] = cr_q[o];
      if (gnt_vld[o] && !(credit_i[o] && PORT_MASK[o])) begin
        cr_d[o] = cr_q[o] - CrW'(1);
      end else if (!gnt_vld[o] && credit_i[o] && PORT_MASK[o] && (cr_q[o] != MaxCr)) begin
        cr_d[o] = cr_q[o] + CrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (accept[p]) mem_q[p][wr_ptr_q[p]] <= data_i[p*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        rd_ptr_q[p] <= '0;
        wr_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
        cr_q[p]     <= MaxCr;
        ptr_q[p]    <= 3'd4;
        dout_q[p]   <= '0;
      end
      valid_q  <= '0;
      credit_q <= '0;
      rerr_q   <= '0;
      ovf_q    <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (pop[p])    rd_ptr_q[p] <= rd_ptr_q[p] + PtrW'(1);
        if (accept[p]) wr_ptr_q[p] <= wr_ptr_q[p] + PtrW'(1);
        cnt_q[p]  <= cnt_d[p];
        cr_q[p]   <= cr_d[p];
        ptr_q[p]  <= ptr_d[p];
        dout_q[p] <= gnt_data[p];
      end
      valid_q  <= gnt_vld;
      credit_q <= pop;
      rerr_q   <= route_bad;
      ovf_q    <= ovf_q | ovf_set;
    end
  end

  always_comb begin
    data_o = '0;
    for (int o = 0; o < NP; o++) begin
      data_o[o*DATA_W +: DATA_W] = dout_q[o];
    end
  end

  assign valid_o     = valid_q;
  assign credit_o    = credit_q;
  assign route_err_o = rerr_q;
  assign ovf_o       = ovf_q;

`ifdef NOC_ROUTER_STATS_EN
  logic [15:0] stat_q [NP];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NP; o++) stat_q[o] <= '0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (gnt_vld[o] && (stat_q[o] != 16'hFFFF)) stat_q[o] <= stat_q[o] + 16'd1;
      end
    end
  end

  always_comb begin
    stats_o = '0;
    for (int o = 0; o < NP; o++) stats_o[o*16 +: 16] = stat_q[o];
  end
`else
  assign stats_o = '0;
`endif

endmodule

// File: tb/tb_noc_mesh_router.sv
// Directed bench for noc_mesh_router at tile (1,1): a full-mask instance with a per-output
// scoreboard, plus an E-less instance for route-error checks.
module tb_noc_mesh_router;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [5*DW-1:0] data_i;
  logic [4:0]      valid_i, credit_i;
  logic [4:0]      credit_o, valid_o, route_err_o, ovf_o;
  logic [5*DW-1:0] data_o;
  logic [79:0]     stats_o;

  logic [5*DW-1:0] m_data_i;
  logic [4:0]      m_valid_i, m_credit_i;
  logic [4:0]      m_credit_o, m_valid_o, m_route_err_o, m_ovf_o;
  logic [5*DW-1:0] m_data_o;
  logic [79:0]     m_stats_o;

  logic [15:0] sb_q [5][$];
  int          rcv [5];
  int          fwd [5];
  logic [4:0]  m_seen;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  noc_mesh_router #(
    .XCOORD(1), .YCOORD(1), .DATA_W(DW), .FIFO_DEPTH(4), .CREDITS(4), .PORT_MASK(5'h1F)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .credit_o(credit_o),
    .data_o(data_o), .valid_o(valid_o), .credit_i(credit_i), .route_err_o(route_err_o),
    .ovf_o(ovf_o), .stats_o(stats_o)
  );

  noc_mesh_router #(
    .XCOORD(1), .YCOORD(1), .DATA_W(DW), .FIFO_DEPTH(4), .CREDITS(4), .PORT_MASK(5'b11011)
  ) dut_m (
    .clk(clk), .rst(rst), .data_i(m_data_i), .valid_i(m_valid_i), .credit_o(m_credit_o),
    .data_o(m_data_o), .valid_o(m_valid_o), .credit_i(m_credit_i), .route_err_o(m_route_err_o),
    .ovf_o(m_ovf_o), .stats_o(m_stats_o)
  );

  function automatic int xy_route(logic [15:0] f);
    if (f[7:4] > 4'd1) return 2;
    if (f[7:4] < 4'd1) return 3;
    if (f[3:0] > 4'd1) return 0;
    if (f[3:0] < 4'd1) return 1;
    return 4;
  endfunction

  // Scoreboard: every valid output flit must match the oldest expected flit for that output.
  always @(negedge clk) begin : mon
    logic [15:0] got;
    logic [15:0] expv;
    m_seen = m_seen | m_valid_o;
    for (int o = 0; o < 5; o++) begin
      if (rst && valid_o[o]) begin
        got = data_o[o*DW +: DW];
        rcv[o]++;
        n_vec++;
        assert (sb_q[o].size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_out%0d: observed %0h expected none", o, got);
        end
        if (sb_q[o].size() != 0) begin
          expv = sb_q[o].pop_front();
          n_vec++;
          assert (got === expv) else begin
            n_err++;
            $error("FAIL data_out%0d: observed %0h expected %0h", o, got, expv);
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [15:0] f);
    int o;
    o = xy_route(f);
    sb_q[o].push_back(f);
    fwd[o]++;
  endtask

  task automatic inject(input int p, input logic [15:0] f, input bit fwd_it);
    data_i[p*DW +: DW] = f;
    valid_i[p] = 1'b1;
    if (fwd_it) push_exp(f);
    tick();
    valid_i[p] = 1'b0;
  endtask

  task automatic clear_model();
    for (int o = 0; o < 5; o++) begin
      sb_q[o].delete();
      rcv[o] = 0;
      fwd[o] = 0;
    end
  endtask

  task automatic pulse_credit(input int o, input int n);
    credit_i[o] = 1'b1;
    tick(n);
    credit_i[o] = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    data_i = '0; valid_i = '0; credit_i = '0;
    m_data_i = '0; m_valid_i = '0; m_credit_i = '0;
    m_seen = '0;
    clear_model();
    #2;
    chk("rst_valid_o", 32'(valid_o), 32'h0);
    chk("rst_credit_o", 32'(credit_o), 32'h0);
    chk("rst_data_o", 32'(|data_o), 32'h0);
    chk("rst_ovf_err", 32'({ovf_o, route_err_o}), 32'h0);
    tick(2);
    rst = 1'b1;
    tick();

    // XY routing and minimum latency
    credit_i = 5'h1F;
    inject(4, 16'hA011, 1'b1);
    chk("lat_cycle1", 32'(valid_o[4]), 32'h0);
    tick();
    chk("lat_cycle2_valid", 32'(valid_o[4]), 32'h1);
    chk("lat_cycle2_credit", 32'(credit_o), 32'h10);
    tick();
    chk("valid_after_idle", 32'(valid_o), 32'h0);
    chk("credit_after_idle", 32'(credit_o), 32'h0);
    inject(4, 16'hA130, 1'b1);
    inject(4, 16'hA210, 1'b1);
    tick(3);
    chk("route_e_count", 32'(rcv[2]), 32'h1);
    chk("route_s_count", 32'(rcv[1]), 32'h1);

    // Round-robin: prime ptr[L] with a grant from N so the sequence starts at S
    inject(0, 16'hB011, 1'b1);
    tick(3);
    for (int r = 0; r < 3; r++) begin
      data_i[0*DW +: DW] = {4'h0, 4'(r), 8'h11};
      data_i[1*DW +: DW] = {4'h1, 4'(r), 8'h11};
      data_i[3*DW +: DW] = {4'h3, 4'(r), 8'h11};
      valid_i = 5'b01011;
      push_exp({4'h1, 4'(r), 8'h11});
      push_exp({4'h3, 4'(r), 8'h11});
      push_exp({4'h0, 4'(r), 8'h11});
      tick();
    end
    valid_i = '0;
    tick(12);
    chk("rr_l_count", 32'(rcv[4]), 32'd11);

    // Mid-traffic reset
    data_i[0*DW +: DW] = 16'hC011;
    valid_i[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_exp(16'hC011);
      tick();
    end
    chk("pre_reset_valid", 32'(valid_o[4]), 32'h1);
    rst = 1'b0;
    valid_i = '0;
    #1;
    chk("midrst_valid_o", 32'(valid_o), 32'h0);
    chk("midrst_credit_o", 32'(credit_o), 32'h0);
    chk("midrst_data_o", 32'(|data_o), 32'h0);
    clear_model();
    credit_i = '0;
    tick();
    rst = 1'b1;
    tick(4);
    chk("post_rst_credit_o", 32'(credit_o), 32'h0);

    // Credit stall on E
    for (int k = 0; k < 6; k++) inject(4, {8'hD0 + 8'(k), 8'h31}, 1'b1);
    tick(6);
    chk("stall_four", 32'(rcv[2]), 32'd4);
    pulse_credit(2, 1);
    tick(3);
    chk("one_more", 32'(rcv[2]), 32'd5);
    pulse_credit(2, 1);
    tick(3);
    chk("drain_sixth", 32'(rcv[2]), 32'd6);
    pulse_credit(2, 5);
    tick();
    for (int k = 0; k < 5; k++) inject(4, {8'hD8 + 8'(k), 8'h31}, 1'b1);
    tick(6);
    chk("credit_saturate", 32'(rcv[2]), 32'd10);
    pulse_credit(2, 1);
    tick(3);
    chk("credit_last", 32'(rcv[2]), 32'd11);

    // Overflow: exhaust S credits, then stuff N with 5 flits
    for (int k = 0; k < 4; k++) inject(3, {8'hE0 + 8'(k), 8'h10}, 1'b1);
    tick(4);
    chk("s_credits_used", 32'(rcv[1]), 32'd4);
    for (int k = 0; k < 4; k++) inject(0, {8'hE8 + 8'(k), 8'h10}, 1'b1);
    chk("ovf_before", 32'(ovf_o), 32'h0);
    inject(0, 16'hEF10, 1'b0);
    chk("ovf_set", 32'(ovf_o), 32'h1);
    tick(3);
    chk("stalled_s", 32'(rcv[1]), 32'd4);
    pulse_credit(1, 4);
    tick(4);
    chk("ovf_drained", 32'(rcv[1]), 32'd8);
    chk("ovf_sticky", 32'(ovf_o), 32'h1);
`ifdef NOC_ROUTER_STATS_EN
    for (int o = 0; o < 5; o++) chk($sformatf("stats_out%0d", o), 32'(stats_o[o*16 +: 16]), 32'(fwd[o]));
`else
    chk("stats_tied", 32'(|stats_o), 32'h0);
`endif

    // Absent E port on the masked instance
    m_credit_i = 5'h1F;
    m_data_i[4*DW +: DW] = 16'hF031;
    m_valid_i[4] = 1'b1;
    tick();
    m_valid_i[4] = 1'b0;
    chk("rerr_early", 32'(m_route_err_o), 32'h0);
    tick();
    chk("rerr_pulse", 32'(m_route_err_o), 32'h10);
    chk("rerr_credit", 32'(m_credit_o), 32'h10);
    tick();
    chk("rerr_once", 32'({m_route_err_o, m_credit_o}), 32'h0);
    m_data_i[2*DW +: DW] = 16'hF111;
    m_valid_i[2] = 1'b1;
    tick();
    m_valid_i[2] = 1'b0;
    tick(3);
    chk("masked_credit", 32'(m_credit_o), 32'h0);
    chk("masked_no_out", 32'(m_seen), 32'h0);
    chk("masked_ovf", 32'(m_ovf_o), 32'h0);

    for (int o = 0; o < 5; o++) chk($sformatf("sb_empty%0d", o), 32'(sb_q[o].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
